// File: rtl/stat_seg_display_pkg.sv
// Shared definitions for the statistics seven-segment display: source select
// codes, digit count, active-low glyph table and converter state encoding.
package stat_seg_display_pkg;

  localparam int unsigned DIGITS = 8;

  localparam logic [2:0] SEL_LED    = 3'd0;
  localparam logic [2:0] SEL_CYCLES = 3'd1;
  localparam logic [2:0] SEL_UNCOND = 3'd2;
  localparam logic [2:0] SEL_COND   = 3'd3;
  localparam logic [2:0] SEL_BUBBLE = 3'd4;

  // Segment order is {dp,g,f,e,d,c,b,a}, a 0 lights the segment.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    B2B_IDLE  = 2'd0,
    B2B_SHIFT = 2'd1,
    B2B_DONE  = 2'd2
  } b2b_state_e;

  // Glyphs 0-9 and A,b,C,d,E,F with dp off.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 8'hC0;
      4'h1:    glyph = 8'hF9;
      4'h2:    glyph = 8'hA4;
      4'h3:    glyph = 8'hB0;
      4'h4:    glyph = 8'h99;
      4'h5:    glyph = 8'h92;
      4'h6:    glyph = 8'h82;
      4'h7:    glyph = 8'hF8;
      4'h8:    glyph = 8'h80;
      4'h9:    glyph = 8'h90;
      4'hA:    glyph = 8'h88;
      4'hB:    glyph = 8'h83;
      4'hC:    glyph = 8'hC6;
      4'hD:    glyph = 8'hA1;
      4'hE:    glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

endpackage

// File: rtl/stat_seg_display_bin2bcd.sv
// Sequential double-dabble converter: 32-bit binary to 10-digit BCD.
// Start is accepted only in IDLE; valid is high for the single DONE cycle,
// 33 cycles after the cycle in which start was presented.
module stat_seg_display_bin2bcd
  import stat_seg_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] bin_i,
  output logic        idle_o,
  output logic        valid_o,
  output logic [39:0] bcd_o
);

  b2b_state_e  state_q;
  logic [31:0] bin_q;
  logic [39:0] bcd_q;
  logic [4:0]  cnt_q;
  logic        valid_q;
  logic [35:0] bcd_adj;

  // Add-3 correction for the lower nine digits. The top digit of a 32-bit
  // input never exceeds 4 while shifting, so it never needs correcting.
  for (genvar gi = 0; gi < 9; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
  end

  // Converter FSM: load on start, 32 correct-and-shift steps, one DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= B2B_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        B2B_IDLE: begin
          if (start_i) begin
            bin_q   <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= B2B_SHIFT;
          end
        end
        B2B_SHIFT: begin
          bcd_q <= {bcd_q[38:36], bcd_adj, bin_q[31]};
          bin_q <= {bin_q[30:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= B2B_DONE;
            valid_q <= 1'b1;
          end
        end
        B2B_DONE: state_q <= B2B_IDLE;
        default:  state_q <= B2B_IDLE;
      endcase
    end
  end

  assign idle_o  = (state_q == B2B_IDLE);
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;

endmodule

// File: rtl/stat_seg_display.sv
// 8-digit multiplexed seven-segment display for CPU LED data and statistics.
// A frame-synchronous snapshot of the selected word is shown in hex, or in
// decimal via the bin2bcd sub-block. Optional build macro:
// SEG_LEAD_ZERO_BLANK_EN blanks leading zero digits in decimal mode.
module stat_seg_display
  import stat_seg_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic        hex_mode,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] uncondi_branch_num,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] bubble_num,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] scan_cnt_q;
  logic [2:0]       digit_idx_q;
  logic [31:0]      snap_val_q;
  logic             snap_hex_q;
  logic [31:0]      bcd_buf_q;
  logic             ovf_q;
  logic             start_pend_q;
  logic [7:0]       an_q, seg_q;
  logic [7:0]       an_d, seg_d;

  logic        scan_wrap, frame_wrap;
  logic [31:0] src_word;
  logic        b2b_start, b2b_idle, b2b_valid;
  logic [31:0] b2b_bin;
  logic [39:0] b2b_bcd;

  assign scan_wrap  = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = scan_wrap && (digit_idx_q == 3'd7);

  // Source word selection; unused codes show zero.
  always_comb begin
    src_word = 32'd0;
    case (sel)
      SEL_LED:    src_word = led_data_in;
      SEL_CYCLES: src_word = total_cycles;
      SEL_UNCOND: src_word = uncondi_branch_num;
      SEL_COND:   src_word = condi_branch_num;
      SEL_BUBBLE: src_word = bubble_num;
      default:    src_word = 32'd0;
    endcase
  end

  // A conversion starts at a decimal frame boundary; if the converter is
  // still finishing (DONE), the start is held pending until it reaches IDLE.
  assign b2b_start = frame_wrap ? !hex_mode : start_pend_q;
  assign b2b_bin   = frame_wrap ? src_word : snap_val_q;

  stat_seg_display_bin2bcd u_b2b (
    .clk     (clk),
    .rst     (rst),
    .start_i (b2b_start),
    .bin_i   (b2b_bin),
    .idle_o  (b2b_idle),
    .valid_o (b2b_valid),
    .bcd_o   (b2b_bcd)
  );

  // Scan timing: per-digit dwell counter and digit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
    end else if (scan_wrap) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= digit_idx_q + 3'd1;
    end else begin
      scan_cnt_q  <= scan_cnt_q + CNT_W'(1);
    end
  end

  // Frame snapshot of the selected word and mode, plus pending-start flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_val_q   <= '0;
      snap_hex_q   <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      if (frame_wrap) begin
        snap_val_q <= src_word;
        snap_hex_q <= hex_mode;
      end
      start_pend_q <= b2b_start && !b2b_idle;
    end
  end

  // Displayed BCD digits only change when a conversion completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_buf_q <= '0;
      ovf_q     <= 1'b0;
    end else if (b2b_valid) begin
      bcd_buf_q <= b2b_bcd[31:0];
      ovf_q     <= |b2b_bcd[39:32];
    end
  end

  logic [3:0] nibble;
  logic [7:0] glyph_w;
  logic       dp_on;
  logic       blank;

`ifdef SEG_LEAD_ZERO_BLANK_EN
  // lead_zero[i] is set when digits i..7 of the BCD buffer are all zero.
  logic [DIGITS:0] lead_zero;
  assign lead_zero[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign lead_zero[gi] = (bcd_buf_q[4*gi +: 4] == 4'd0) && lead_zero[gi+1];
  end
  assign blank = !snap_hex_q && !ovf_q && (digit_idx_q != 3'd0) &&
                 lead_zero[digit_idx_q];
`else
  assign blank = 1'b0;
`endif

  // Digit mux and glyph decode for the currently scanned digit.
  always_comb begin
    nibble  = snap_hex_q ? snap_val_q[{digit_idx_q, 2'b00} +: 4]
                         : bcd_buf_q[{digit_idx_q, 2'b00} +: 4];
    glyph_w = glyph(nibble);
    dp_on   = !snap_hex_q && ovf_q;
    seg_d   = blank ? SEG_BLANK : (glyph_w & {~dp_on, 7'h7F});
    an_d    = ~(8'd1 << digit_idx_q);
  end

  // Registered display outputs; reset shows "0" on digit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q  <= 8'hFE;
      seg_q <= 8'hC0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_stat_seg_display.sv
// Directed bench for stat_seg_display with SCAN_DIV = 40.
module tb_stat_seg_display;
  import stat_seg_display_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic        hex_mode;
  logic [31:0] led_data_in, total_cycles, uncondi_branch_num;
  logic [31:0] condi_branch_num, bubble_num;
  logic [7:0]  an, seg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stat_seg_display #(.SCAN_DIV(40)) dut (
    .clk                (clk),
    .rst                (rst),
    .sel                (sel),
    .hex_mode           (hex_mode),
    .led_data_in        (led_data_in),
    .total_cycles       (total_cycles),
    .uncondi_branch_num (uncondi_branch_num),
    .condi_branch_num   (condi_branch_num),
    .bubble_num         (bubble_num),
    .an                 (an),
    .seg                (seg)
  );

  function automatic logic [7:0] g(input logic [3:0] d);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[d];
  endfunction

  // Expected segments for all 8 digits, digit i in bits [8i+7:8i].
  function automatic logic [63:0] frame_of(input logic [31:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = g(v[4*i +: 4]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until an equals / differs from target, sampled 1 ns after posedge.
  task automatic wait_an(input logic [7:0] target, input bit want_eq);
    bit ok = 0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if ((an === target) == want_eq) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL timeout waiting an=%02h (eq=%0d) observed=%02h", target, want_eq, an);
    end
  endtask

  task automatic wait_frame_start();
    wait_an(8'hFE, 0);
    wait_an(8'hFE, 1);
  endtask

  task automatic check_digit(input string tag, input int i, input logic [7:0] exp);
    wait_an(8'(~(8'd1 << i)), 1);
    check($sformatf("%s_d%0d", tag, i), {56'd0, seg}, {56'd0, exp});
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp);
    wait_frame_start();
    $display("frame %s", tag);
    check($sformatf("%s_d0", tag), {56'd0, seg}, {56'd0, exp[7:0]});
    for (int i = 1; i < 8; i++) check_digit(tag, i, exp[8*i +: 8]);
  endtask

  initial begin
    int n;
    logic [63:0] exp;

    rst = 1'b0; sel = 3'd1; hex_mode = 1'b1;
    led_data_in = 32'd0; total_cycles = 32'h1234ABCD;
    uncondi_branch_num = 32'hFFFFFFFF; condi_branch_num = 32'd87654321;
    bubble_num = 32'd12345678;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("reset_an", {56'd0, an}, 64'hFE);
    check("reset_seg", {56'd0, seg}, 64'hC0);
    @(negedge clk) rst = 1'b1;

    // Index advances on the 40th edge after release; an follows on the 41st.
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1; n++;
      if (an !== 8'hFE) break;
    end
    check("first_advance", 64'(n), 64'd41);

    // Hex mode, total_cycles: 1,2,3,4,A,b,C,d left to right.
    check_frame("hex_1234ABCD", frame_of(32'h1234ABCD));

    // Decimal 12345678 from bubble_num; first frame may show old digit 0.
    sel = 3'd4; hex_mode = 1'b0;
    wait_frame_start();
    check_frame("dec_12345678", frame_of(32'h12345678));

    // Decimal 0xFFFFFFFF: low 8 digits 94967295, all dp lit.
    sel = 3'd2; hex_mode = 1'b0;
    wait_frame_start();
    check_frame("dec_ffffffff_ovf", frame_of(32'h94967295) & {8{8'h7F}});

    // Mid-frame sel change 1 -> 2 (both hex): current frame unchanged.
    sel = 3'd1; hex_mode = 1'b1;
    wait_frame_start();
    exp = frame_of(32'h1234ABCD);
    check("midsel_d0", {56'd0, seg}, {56'd0, exp[7:0]});
    for (int i = 1; i < 4; i++) check_digit("midsel", i, exp[8*i +: 8]);
    sel = 3'd2;
    for (int i = 4; i < 8; i++) check_digit("midsel", i, exp[8*i +: 8]);
    check_frame("after_sel2_hex", frame_of(32'hFFFFFFFF));

    // Reset during SHIFT cycle 10 of a conversion of 87654321.
    sel = 3'd3; hex_mode = 1'b0;
    wait_frame_start();
    repeat (9) @(posedge clk);
    #1;
    check("b2b_shift_before_rst", 64'(dut.u_b2b.state_q), 64'(B2B_SHIFT));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b2b_idle_after_rst", 64'(dut.u_b2b.state_q), 64'(B2B_IDLE));
    check("b2b_bcd_after_rst", 64'(dut.u_b2b.bcd_o), 64'd0);
    @(negedge clk) rst = 1'b1;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    exp = {{7{8'hFF}}, 8'hC0};
`else
    exp = frame_of(32'h00000000);
`endif
    for (int i = 0; i < 8; i++) check_digit("zero_after_rst", i, exp[8*i +: 8]);
    wait_frame_start();
    check_frame("dec_87654321", frame_of(32'h87654321));

    // Decimal 507 from led_data_in; leading zeros blanked when enabled.
    sel = 3'd0; hex_mode = 1'b0; led_data_in = 32'd507;
    wait_frame_start();
`ifdef SEG_LEAD_ZERO_BLANK_EN
    exp = {{5{8'hFF}}, g(4'd5), g(4'd0), g(4'd7)};
`else
    exp = frame_of(32'h00000507);
`endif
    check_frame("dec_507", exp);

    // Unused select code shows zero in hex.
    sel = 3'd5; hex_mode = 1'b1;
    check_frame("sel5_zero", frame_of(32'h00000000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
